// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared FSM state encoding and count-direction constants
package counter_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
endpackage

// File: rtl/counter_ctrl_btn_debounce.sv
// btn_debounce: synchronizes a raw button, accepts a level after it is stable, pulses once per press
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, stb, stb_d;
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      stb   <= 1'b0;
      stb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      stb_d <= stb;
      if (sync2 == stb) cnt <= '0;
      else if (cnt == LAST) begin
        stb <= sync2;
        cnt <= '0;
      end else cnt <= cnt + W'(1);
    end
  end
  assign btn_pulse = stb & ~stb_d;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: debounced STOP/RUN/CLEAR control of counter tick, clear and direction
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_run_stop,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       tick_in,
  output logic       cnt_tick,
  output logic       cnt_clear,
  output logic       cnt_mode,
  output logic [1:0] state
);
  state_t st;
  logic run_p, clear_p, mode_p;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clk(clk), .reset(reset), .btn_raw(btn_run_stop), .btn_pulse(run_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .reset(reset), .btn_raw(btn_clear), .btn_pulse(clear_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .btn_raw(btn_mode), .btn_pulse(mode_p));
  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= ST_STOP;
      cnt_mode  <= MODE_UP;
      cnt_tick  <= 1'b0;
      cnt_clear <= 1'b0;
    end else begin
      cnt_tick  <= tick_in && st == ST_RUN;
      cnt_clear <= 1'b0;
      if (mode_p) cnt_mode <= ~cnt_mode;
      case (st)
        ST_STOP:
          if (clear_p) begin
            st        <= ST_CLEAR;
            cnt_clear <= 1'b1;
          end else if (run_p) st <= ST_RUN;
        ST_RUN:  if (run_p) st <= ST_STOP;
        default: st <= ST_STOP;
      endcase
    end
  end
  assign state = st;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scenario checks of counter_ctrl with DEBOUNCE_CYCLES = 4
module tb_counter_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic btn_run_stop = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0, tick_in = 1'b0;
  logic cnt_tick, cnt_clear, cnt_mode;
  logic [1:0] state;
  int checks = 0, errors = 0;
  counter_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
    .btn_mode(btn_mode), .tick_in(tick_in), .cnt_tick(cnt_tick), .cnt_clear(cnt_clear),
    .cnt_mode(cnt_mode), .state(state));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (cnt_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", cnt_mode); end
    checks++; if (cnt_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", cnt_tick); end
    checks++; if (cnt_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", cnt_clear); end
    reset = 1'b0;
  endtask
  task automatic test_run_tick;
    btn_run_stop = 1'b1;
    tick(6);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL run_early got %0d want 0", state); end
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_enter got %0d want 1", state); end
    tick(3);
    btn_run_stop = 1'b0;
    tick(8);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_release got %0d want 1", state); end
    tick_in = 1'b1;
    tick(1);
    tick_in = 1'b0;
    checks++; if (cnt_tick !== 1'b1) begin errors++; $display("FAIL tick_pass got %b want 1", cnt_tick); end
    tick(1);
    checks++; if (cnt_tick !== 1'b0) begin errors++; $display("FAIL tick_one got %b want 0", cnt_tick); end
    btn_run_stop = 1'b1;
    tick(6);
    tick_in = 1'b1;
    tick(1);
    tick_in = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL run_stop got %0d want 0", state); end
    checks++; if (cnt_tick !== 1'b1) begin errors++; $display("FAIL tick_at_stop got %b want 1", cnt_tick); end
    tick(3);
    btn_run_stop = 1'b0;
    tick(8);
    tick_in = 1'b1;
    tick(1);
    tick_in = 1'b0;
    checks++; if (cnt_tick !== 1'b0) begin errors++; $display("FAIL tick_blocked got %b want 0", cnt_tick); end
  endtask
  task automatic test_bounce;
    logic [4:0] seq = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btn_mode = seq[i];
      tick(1);
    end
    btn_mode = 1'b1;
    tick(5);
    checks++; if (cnt_mode !== 1'b0) begin errors++; $display("FAIL bounce_early got %b want 0", cnt_mode); end
    tick(3);
    checks++; if (cnt_mode !== 1'b1) begin errors++; $display("FAIL bounce_toggle got %b want 1", cnt_mode); end
    btn_mode = 1'b0;
    tick(8);
    checks++; if (cnt_mode !== 1'b1) begin errors++; $display("FAIL bounce_release got %b want 1", cnt_mode); end
  endtask
  task automatic test_clear;
    btn_clear = 1'b1;
    tick(6);
    checks++; if (cnt_clear !== 1'b0) begin errors++; $display("FAIL clear_early got %b want 0", cnt_clear); end
    tick(1);
    checks++; if (state !== 2'd2 || cnt_clear !== 1'b1) begin errors++; $display("FAIL clear_enter got state %0d clear %b want 2/1", state, cnt_clear); end
    tick(1);
    checks++; if (state !== 2'd0 || cnt_clear !== 1'b0) begin errors++; $display("FAIL clear_exit got state %0d clear %b want 0/0", state, cnt_clear); end
    tick(2);
    btn_clear = 1'b0;
    tick(8);
    btn_run_stop = 1'b1;
    tick(7);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL clear_run_setup got %0d want 1", state); end
    tick(3);
    btn_run_stop = 1'b0;
    tick(8);
    btn_clear = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick(1);
        if (cnt_clear) seen = 1'b1;
      end
      checks++; if (seen || state !== 2'd1) begin errors++; $display("FAIL clear_in_run got state %0d clear_seen %b want 1/0", state, seen); end
    end
    btn_clear = 1'b0;
    tick(8);
    btn_run_stop = 1'b1;
    tick(10);
    btn_run_stop = 1'b0;
    tick(8);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_back_stop got %0d want 0", state); end
  endtask
  task automatic test_simultaneous;
    btn_clear = 1'b1;
    btn_run_stop = 1'b1;
    tick(7);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL simul_clear got %0d want 2", state); end
    begin
      bit ran = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (state == 2'd1) ran = 1'b1;
      end
      checks++; if (ran || state !== 2'd0) begin errors++; $display("FAIL simul_no_run got state %0d ran %b want 0/0", state, ran); end
    end
    btn_clear = 1'b0;
    btn_run_stop = 1'b0;
    tick(8);
    btn_mode = 1'b1;
    btn_run_stop = 1'b1;
    tick(7);
    checks++; if (state !== 2'd1 || cnt_mode !== 1'b0) begin errors++; $display("FAIL simul_mode_run got state %0d mode %b want 1/0", state, cnt_mode); end
    tick(3);
    btn_mode = 1'b0;
    btn_run_stop = 1'b0;
    tick(8);
  endtask
  task automatic test_reset_mid;
    btn_mode = 1'b1;
    btn_run_stop = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++; if (state !== 2'd0 || cnt_mode !== 1'b0) begin errors++; $display("FAIL rst_mid got state %0d mode %b want 0/0", state, cnt_mode); end
    reset = 1'b0;
    btn_mode = 1'b0;
    tick(6);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_no_early got %0d want 0", state); end
    tick(1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_fresh_press got %0d want 1", state); end
    tick(6);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_single_pulse got %0d want 1", state); end
    btn_run_stop = 1'b0;
    tick(8);
  endtask
  initial begin
    tick(1);
    test_reset;
    test_run_tick;
    test_bounce;
    test_clear;
    test_simultaneous;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Button-driven controller for the 14-bit up/down BCD-range counter. Debounces three raw push-buttons (run/stop, clear, mode) and runs a STOP/RUN/CLEAR state machine. Its outputs gate the 10 Hz tick into the counter, issue a one-cycle clear, and hold the count direction. It sits between board I/O and the tick divider/counter pair, replacing the direct switch-to-mode wiring.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must be stable before it is accepted (10 ms at 100 MHz); must be ≥ 2.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_run_stop  in  1  raw button, asynchronous to clk, active-high.
- btn_clear  in  1  raw button, asynchronous, active-high.
- btn_mode  in  1  raw button, asynchronous, active-high.
- tick_in  in  1  one-cycle 10 Hz tick from the clock divider.
- cnt_tick  out  1  gated tick to the counter; registered.
- cnt_clear  out  1  one-cycle synchronous clear request to the counter.
- cnt_mode  out  1  count direction: 0 = up, 1 = down.
- state  out  2  current FSM state, for LEDs and debug.

## Operation
- **Debounce, per button:**
  - 2-FF synchronizer, then stable-level register `stb`.
  - Counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - Each edge: if sync ≠ stb, then cnt increments. When cnt == DEBOUNCE_CYCLES-1 with a mismatch, stb <= sync and cnt <= 0.
  - If sync == stb, cnt <= 0, so any bounce restarts the count.
  - Press pulse = stb & ~stb_d. Exactly one cycle per accepted press; release produces no pulse.
- **FSM states:** ST_STOP, ST_RUN, ST_CLEAR.
  - ST_STOP:
    - clear pulse → ST_CLEAR.
    - else run_stop pulse → ST_RUN.
    - Clear beats run_stop when both arrive in the same cycle.
  - ST_RUN:
    - run_stop pulse → ST_STOP.
    - clear pulse is ignored; a counting clock cannot be cleared.
  - ST_CLEAR: unconditional → ST_STOP after one cycle. Pulses arriving in this cycle are dropped.
- **cnt_mode:**
  - Toggles on a mode pulse in any state.
  - A mode pulse simultaneous with another pulse applies both.
- **cnt_clear:** 1 exactly while state == ST_CLEAR.
- **cnt_tick:** registered `tick_in && state == ST_RUN` (state as seen in the same cycle).
- **Reset values:** state = ST_STOP, cnt_mode = 0, cnt_tick = 0, cnt_clear = 0. Synchronizers, stb, stb_d and cnt are all 0.
- **Reset mid-operation:**
  - Reset asserted in any state returns to ST_STOP on the next edge and drops an in-flight debounce count.
  - A button held through reset release is accepted only after a fresh DEBOUNCE_CYCLES, and then produces a pulse.

## Timing
- Edge 0 is the first edge that samples a raw button high (held clean). Then:
  - edge 1: sync valid.
  - edges 2..D: counting, where D = DEBOUNCE_CYCLES.
  - edge D+1: stb rises.
  - cycle after edge D+1: pulse is high.
  - edge D+2: FSM and cnt_mode update.
- cnt_tick lags tick_in by exactly 1 cycle. A tick_in that coincides with the RUN→STOP edge still propagates, because it samples the old state.
- cnt_clear is high for the one cycle after the edge that enters ST_CLEAR.
- The counter sees the clear and the tick on the same clk with no CDC.

## Structure
- **counter_ctrl_pkg:**
  - typedef enum logic [1:0] state_t, with ST_STOP = 0, ST_RUN = 1, ST_CLEAR = 2.
  - Value 3 is illegal and must recover to ST_STOP.
  - localparam MODE_UP = 1'b0, MODE_DOWN = 1'b1.
- **Sub-module btn_debounce:**
  - Parameter DEBOUNCE_CYCLES; ports clk, reset, btn_raw, btn_pulse.
  - Instantiated three times.
- The FSM, the mode toggle and the tick gate live in counter_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. **Reset:** assert reset for 3 cycles with buttons low → state = 0, cnt_mode = 0, cnt_tick = 0, cnt_clear = 0.
2. **Clean press and tick gating:** clean btn_run_stop press held 10 cycles → single pulse; state = ST_RUN at edge 6 after first sample. A tick_in pulse then yields cnt_tick one cycle later. A second press gives ST_STOP, and later ticks are blocked.
3. **Bounce:** btn_mode toggling 1,0,1,1,0 (shorter than 4 stable cycles), then held high 8 cycles → exactly one cnt_mode toggle (0 → 1); no toggle on release.
4. **Clear:**
   - In ST_STOP, a clear press → cnt_clear high exactly 1 cycle, then ST_STOP.
   - In ST_RUN, a clear press → cnt_clear stays 0 and state stays ST_RUN.
5. **Simultaneous presses:** clear and run_stop pressed on the same cycle in ST_STOP → ST_CLEAR then ST_STOP, never ST_RUN. Mode pressed together with run_stop → both ST_RUN and a cnt_mode toggle.
6. **Reset mid-operation:** reset mid-debounce (btn held) and in ST_RUN → ST_STOP, no pulse until 4 stable cycles after reset release, then one pulse.
